// File: rtl/sprite_frame_scheduler_pkg.sv
// Shared constants for the sprite frame scheduler: sprite geometry, screen size defaults,
// FSM state encodings and a small width helper.
package sprite_frame_scheduler_pkg;

    localparam int SPRITE_DIM   = 4;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LATCH  = 3'd1;
    localparam logic [2:0] SELECT = 3'd2;
    localparam logic [2:0] ERASE  = 3'd3;
    localparam logic [2:0] DRAW   = 3'd4;
    localparam logic [2:0] NEXT   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    // Index width for a set of n requesters; a single requester still needs one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_frame_scheduler_block_plotter.sv
// Walks one 4x4 block a pixel per cycle from a start strobe, clips against the screen
// and registers the resulting VGA write.
module sprite_frame_scheduler_block_plotter
    import sprite_frame_scheduler_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       start,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [2:0] colour,
    output logic       last,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] pix_colour,
    output logic       plot
);

    localparam logic [3:0] LAST_PIXEL = 4'(SPRITE_DIM * SPRITE_DIM - 1);

    logic       active_reg;
    logic [3:0] cnt_reg;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       on_screen;
    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic [2:0] colour_reg;
    logic       plot_reg;

    // Sums are one bit wider than the port so off-screen pixels are caught, not wrapped.
    assign sum_x     = {1'b0, base_x} + {7'd0, cnt_reg[1:0]};
    assign sum_y     = {1'b0, base_y} + {6'd0, cnt_reg[3:2]};
    assign on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    assign last      = active_reg && (cnt_reg == LAST_PIXEL);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
        end else begin
            if (start) begin
                active_reg <= 1'b1;
                cnt_reg    <= '0;
            end else if (active_reg) begin
                cnt_reg <= cnt_reg + 4'd1;
                if (cnt_reg == LAST_PIXEL) begin
                    active_reg <= 1'b0;
                end
            end
            x_reg      <= active_reg ? sum_x[7:0] : '0;
            y_reg      <= active_reg ? sum_y[6:0] : '0;
            colour_reg <= active_reg ? colour : '0;
            plot_reg   <= active_reg && on_screen;
        end
    end

    assign x          = x_reg;
    assign y          = y_reg;
    assign pix_colour = colour_reg;
    assign plot       = plot_reg;

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Shares one VGA pixel-write port among several 4x4 sprites: on each frame tick every sprite
// is visited round-robin, its old image erased and its new image drawn.
module sprite_frame_scheduler
    import sprite_frame_scheduler_pkg::*;
#(
    parameter int         NUM_SPRITES = 2,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter int         SCREEN_W    = DEF_SCREEN_W,
    parameter int         SCREEN_H    = DEF_SCREEN_H
) (
    input  logic                     iClock,
    input  logic                     iResetn,
    input  logic                     iFrameTick,
    input  logic [NUM_SPRITES-1:0]   iReqValid,
    input  logic [8*NUM_SPRITES-1:0] iReqX,
    input  logic [7*NUM_SPRITES-1:0] iReqY,
    input  logic [3*NUM_SPRITES-1:0] iReqColour,
    output logic [NUM_SPRITES-1:0]   oReqAck,
    output logic [7:0]               oX,
    output logic [6:0]               oY,
    output logic [2:0]               oColour,
    output logic                     oPlot,
    output logic                     oBusy,
    output logic                     oDone,
    output logic                     oOverrun
);

    localparam int               IDX_W    = index_width(NUM_SPRITES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    logic [7:0] req_x [NUM_SPRITES];
    logic [6:0] req_y [NUM_SPRITES];
    logic [2:0] req_c [NUM_SPRITES];

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_unpack
            assign req_x[gi] = iReqX[8*gi +: 8];
            assign req_y[gi] = iReqY[7*gi +: 7];
            assign req_c[gi] = iReqColour[3*gi +: 3];
        end
    endgenerate

    logic [2:0]             state_reg, state_next;
    logic [IDX_W-1:0]       rr_reg, sel_reg, visited_reg;
    logic                   pending_reg, overrun_reg, start_reg;
    logic [NUM_SPRITES-1:0] valid_reg, drawn_reg, ack_reg;
    logic [7:0]             lat_x_reg  [NUM_SPRITES];
    logic [6:0]             lat_y_reg  [NUM_SPRITES];
    logic [2:0]             lat_c_reg  [NUM_SPRITES];
    logic [7:0]             last_x_reg [NUM_SPRITES];
    logic [6:0]             last_y_reg [NUM_SPRITES];

    logic [7:0] plot_base_x;
    logic [6:0] plot_base_y;
    logic [2:0] plot_colour;
    logic       plot_last;

    // Erase walks the previously drawn position in background colour; draw uses this frame's snapshot.
    always_comb begin
        plot_base_x = last_x_reg[sel_reg];
        plot_base_y = last_y_reg[sel_reg];
        plot_colour = BG_COLOUR;
        if (state_reg == DRAW) begin
            plot_base_x = lat_x_reg[sel_reg];
            plot_base_y = lat_y_reg[sel_reg];
            plot_colour = lat_c_reg[sel_reg];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (iFrameTick || pending_reg) state_next = LATCH;
            LATCH:   state_next = SELECT;
            SELECT: begin
                if (drawn_reg[sel_reg])      state_next = ERASE;
                else if (valid_reg[sel_reg]) state_next = DRAW;
                else                         state_next = NEXT;
            end
            ERASE:   if (plot_last) state_next = valid_reg[sel_reg] ? DRAW : NEXT;
            DRAW:    if (plot_last) state_next = NEXT;
            NEXT:    state_next = (visited_reg == LAST_IDX) ? DONE : SELECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_reg   <= IDLE;
            rr_reg      <= '0;
            sel_reg     <= '0;
            visited_reg <= '0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
            start_reg   <= 1'b0;
            valid_reg   <= '0;
            drawn_reg   <= '0;
            ack_reg     <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                lat_x_reg[i]  <= '0;
                lat_y_reg[i]  <= '0;
                lat_c_reg[i]  <= '0;
                last_x_reg[i] <= '0;
                last_y_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            overrun_reg <= 1'b0;
            ack_reg     <= '0;
            // The plotter is kicked once on each entry into a pixel-walking state.
            start_reg   <= ((state_next == ERASE) || (state_next == DRAW)) && (state_next != state_reg);

            // One tick may queue behind a running frame; any further tick is lost.
            if (iFrameTick && (state_reg != IDLE)) begin
                if (pending_reg) overrun_reg <= 1'b1;
                else             pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: if (state_next == LATCH) pending_reg <= 1'b0;
                LATCH: begin
                    valid_reg   <= iReqValid;
                    sel_reg     <= rr_reg;
                    visited_reg <= '0;
                    for (int i = 0; i < NUM_SPRITES; i++) begin
                        lat_x_reg[i] <= req_x[i];
                        lat_y_reg[i] <= req_y[i];
                        lat_c_reg[i] <= req_c[i];
                    end
                end
                ERASE: if (plot_last) drawn_reg[sel_reg] <= 1'b0;
                DRAW: begin
                    if (plot_last) begin
                        last_x_reg[sel_reg] <= lat_x_reg[sel_reg];
                        last_y_reg[sel_reg] <= lat_y_reg[sel_reg];
                        drawn_reg[sel_reg]  <= 1'b1;
                        ack_reg[sel_reg]    <= 1'b1;
                    end
                end
                NEXT: begin
                    visited_reg <= visited_reg + IDX_W'(1);
                    sel_reg     <= wrap_inc(sel_reg);
                end
                DONE:    rr_reg <= wrap_inc(rr_reg);
                default: ;
            endcase
        end
    end

    sprite_frame_scheduler_block_plotter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_block_plotter (
        .iClock     (iClock),
        .iResetn    (iResetn),
        .start      (start_reg),
        .base_x     (plot_base_x),
        .base_y     (plot_base_y),
        .colour     (plot_colour),
        .last       (plot_last),
        .x          (oX),
        .y          (oY),
        .pix_colour (oColour),
        .plot       (oPlot)
    );

    assign oReqAck  = ack_reg;
    assign oBusy    = (state_reg != IDLE);
    assign oDone    = (state_reg == DONE);
    assign oOverrun = overrun_reg;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Self-checking bench for sprite_frame_scheduler: directed frame table, busy-tick and reset
// sequences, then random frames compared against a pixel-list reference model.
module tb_sprite_frame_scheduler;

    localparam int         N  = 2;
    localparam logic [2:0] BG = 3'b000;

    logic           iClock;
    logic           iResetn;
    logic           iFrameTick;
    logic [N-1:0]   iReqValid;
    logic [8*N-1:0] iReqX;
    logic [7*N-1:0] iReqY;
    logic [3*N-1:0] iReqColour;
    logic [N-1:0]   oReqAck;
    logic [7:0]     oX;
    logic [6:0]     oY;
    logic [2:0]     oColour;
    logic           oPlot, oBusy, oDone, oOverrun;

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    sprite_frame_scheduler #(
        .NUM_SPRITES (N),
        .BG_COLOUR   (BG),
        .SCREEN_W    (160),
        .SCREEN_H    (120)
    ) dut (
        .iClock     (iClock),
        .iResetn    (iResetn),
        .iFrameTick (iFrameTick),
        .iReqValid  (iReqValid),
        .iReqX      (iReqX),
        .iReqY      (iReqY),
        .iReqColour (iReqColour),
        .oReqAck    (oReqAck),
        .oX         (oX),
        .oY         (oY),
        .oColour    (oColour),
        .oPlot      (oPlot),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oOverrun   (oOverrun)
    );

    int total, bad;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int outs();
        return int'({oX, oY, oColour, oPlot, oBusy, oDone, oOverrun, oReqAck});
    endfunction

    // Stimulus for the next frame
    logic [N-1:0] s_valid;
    int           s_x [N];
    int           s_y [N];
    int           s_c [N];

    // Reference model: per-sprite drawn/last position and the round-robin start
    int m_rr;
    bit m_drawn [N];
    int m_lx [N];
    int m_ly [N];
    int exp_pix[$], got_pix[$], exp_ack[$], got_ack[$];

    // Capture results
    int n_bg, n_ovr, first_edge, done_cyc, dones;

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < N; i++) begin
            m_drawn[i] = 1'b0;
            m_lx[i]    = 0;
            m_ly[i]    = 0;
        end
    endtask

    task automatic push_block(input int bx, input int by, input int col);
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                if ((bx + dx) < 160 && (by + dy) < 120)
                    exp_pix.push_back(((bx + dx) << 10) | ((by + dy) << 3) | col);
            end
        end
    endtask

    task automatic model_frame();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (m_drawn[i]) begin
                push_block(m_lx[i], m_ly[i], int'(BG));
                m_drawn[i] = 1'b0;
            end
            if (s_valid[i]) begin
                push_block(s_x[i], s_y[i], s_c[i]);
                exp_ack.push_back(i);
                m_drawn[i] = 1'b1;
                m_lx[i]    = s_x[i];
                m_ly[i]    = s_y[i];
            end
        end
        m_rr = (m_rr + 1) % N;
    endtask

    task automatic begin_expect();
        exp_pix.delete();
        exp_ack.delete();
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            iReqValid[i]         = s_valid[i];
            iReqX[8*i +: 8]      = 8'(s_x[i]);
            iReqY[7*i +: 7]      = 7'(s_y[i]);
            iReqColour[3*i +: 3] = 3'(s_c[i]);
        end
    endtask

    // Called at posedge+1 with the DUT idle; extra ticks are sampled at edges t2 and t3.
    task automatic run_frames(input int n_frames, input int t2, input int t3);
        got_pix.delete();
        got_ack.delete();
        n_bg = 0; n_ovr = 0; first_edge = -1; done_cyc = -1; dones = 0;
        iFrameTick = 1'b1;
        for (int cyc = 1; cyc <= 600 && dones < n_frames; cyc++) begin
            @(posedge iClock); #1;
            if (oPlot) begin
                got_pix.push_back(int'({oX, oY, oColour}));
                if (first_edge < 0) first_edge = cyc - 1;
                if (oColour == BG) n_bg++;
            end
            for (int i = 0; i < N; i++) if (oReqAck[i]) got_ack.push_back(i);
            if (oOverrun) n_ovr++;
            if (oDone) begin
                dones++;
                done_cyc = cyc;
            end
            iFrameTick = (cyc == t2) || (cyc == t3);
        end
        iFrameTick = 1'b0;
        chk("frame_done_within_budget", dones, n_frames);
        @(posedge iClock); #1;
    endtask

    task automatic compare_model(input string tag, input int exp_ovr);
        chk({tag, "_plot_count"}, got_pix.size(), exp_pix.size());
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++)
            chk($sformatf("%s_pix%0d", tag, i), got_pix[i], exp_pix[i]);
        chk({tag, "_ack_count"}, got_ack.size(), exp_ack.size());
        for (int i = 0; i < got_ack.size() && i < exp_ack.size(); i++)
            chk($sformatf("%s_ack%0d", tag, i), got_ack[i], exp_ack[i]);
        chk({tag, "_overrun"}, n_ovr, exp_ovr);
        $display("frame %s: plots=%0d bg=%0d acks=%0d overruns=%0d done_cyc=%0d",
                 tag, got_pix.size(), n_bg, got_ack.size(), n_ovr, done_cyc);
    endtask

    typedef struct {
        logic [1:0] valid;
        int x0, y0, c0, x1, y1, c1;
        int exp_plots, exp_bg, exp_first_ack, exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int len1;
        bit seen;
        total = 0;
        bad   = 0;
        len1  = 0;

        vecs[0] = '{2'b01,  50,  50, 4,  0,  0, 1, 16,  0,  0, 4};
        vecs[1] = '{2'b01,  51,  50, 4,  0,  0, 1, 32, 16,  0, 0};
        vecs[2] = '{2'b01, 158, 118, 4,  0,  0, 1, 20, 16,  0, 0};
        vecs[3] = '{2'b00, 158, 118, 4,  0,  0, 1,  4,  4, -1, 0};
        vecs[4] = '{2'b11,  10,  10, 1, 20, 20, 2, 32,  0,  0, 4};
        vecs[5] = '{2'b11,  12,  10, 1, 20, 24, 2, 64, 32,  1, 0};
        vecs[6] = '{2'b11,  14,  10, 5, 20, 28, 6, 64, 32,  0, 0};

        iResetn    = 1'b0;
        iFrameTick = 1'b0;
        iReqValid  = '0;
        iReqX      = '0;
        iReqY      = '0;
        iReqColour = '0;
        model_reset();

        // A tick during reset must be ignored.
        @(posedge iClock); #1;
        iReqValid  = 2'b11;
        iFrameTick = 1'b1;
        @(posedge iClock); #1;
        iFrameTick = 1'b0;
        chk("reset_outputs", outs(), 0);
        iResetn = 1'b1;
        repeat (3) @(posedge iClock);
        #1;
        chk("reset_idle_busy", int'(oBusy), 0);
        chk("reset_outputs_after", outs(), 0);

        for (int t = 0; t < 7; t++) begin
            int fa;
            s_valid = vecs[t].valid;
            s_x[0] = vecs[t].x0; s_y[0] = vecs[t].y0; s_c[0] = vecs[t].c0;
            s_x[1] = vecs[t].x1; s_y[1] = vecs[t].y1; s_c[1] = vecs[t].c1;
            apply_inputs();
            begin_expect();
            model_frame();
            run_frames(1, -1, -1);
            compare_model($sformatf("vec%0d", t), 0);
            chk($sformatf("vec%0d_plots", t), got_pix.size(), vecs[t].exp_plots);
            chk($sformatf("vec%0d_bg", t), n_bg, vecs[t].exp_bg);
            fa = (got_ack.size() > 0) ? got_ack[0] : -1;
            chk($sformatf("vec%0d_first_ack", t), fa, vecs[t].exp_first_ack);
            if (vecs[t].exp_lat > 0)
                chk($sformatf("vec%0d_latency", t), first_edge, vecs[t].exp_lat);
            if (t == 1) len1 = done_cyc;
            if (t == 2) chk("clip_frame_len", done_cyc, len1);
        end

        // One tick during a busy frame queues a second frame.
        s_valid = 2'b01;
        apply_inputs();
        begin_expect();
        model_frame();
        model_frame();
        run_frames(2, 10, -1);
        compare_model("tick_once", 0);
        repeat (3) @(posedge iClock);
        #1;
        chk("tick_once_no_third_frame", int'(oBusy), 0);

        // Two ticks during a busy frame: one queued, one dropped with an overrun pulse.
        begin_expect();
        model_frame();
        model_frame();
        run_frames(2, 10, 15);
        compare_model("tick_twice", 1);
        repeat (3) @(posedge iClock);
        #1;
        chk("tick_twice_no_third_frame", int'(oBusy), 0);

        // Reset asserted in the middle of an erase.
        s_valid = 2'b01; s_x[0] = 30; s_y[0] = 30; s_c[0] = 3;
        apply_inputs();
        iFrameTick = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            @(posedge iClock); #1;
            iFrameTick = 1'b0;
            if (oPlot && oColour == BG) seen = 1'b1;
        end
        chk("mid_erase_reached", int'(seen), 1);
        repeat (2) @(posedge iClock);
        #1;
        iResetn = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        @(posedge iClock); #1;
        iResetn = 1'b1;
        model_reset();
        @(posedge iClock); #1;
        begin_expect();
        model_frame();
        run_frames(1, -1, -1);
        compare_model("post_reset", 0);
        chk("post_reset_no_erase", n_bg, 0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                s_valid[i] = 1'($urandom_range(0, 1));
                s_x[i]     = int'($urandom_range(0, 170));
                s_y[i]     = int'($urandom_range(0, 125));
                s_c[i]     = int'($urandom_range(1, 7));
            end
            apply_inputs();
            begin_expect();
            model_frame();
            run_frames(1, -1, -1);
            compare_model($sformatf("rand%0d", f), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
